// File: rtl/irq_pkg.sv
// Shared CSR addresses, bit positions, cause codes and FSM state type for irq_ctrl.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package irq_pkg;

  // CSR addresses owned by the interrupt controller
  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MIP     = 12'h344;

  // mstatus bit positions
  localparam int MIE_BIT  = 3;
  localparam int MPIE_BIT = 7;

  // mie/mip bit positions
  localparam int MSI = 3;
  localparam int MTI = 7;
  localparam int MEI = 11;

  // Writable bits of mie
  localparam logic [31:0] MIE_MASK = 32'h0000_0888;

  // Interrupt cause codes (low nibble of mcause)
  localparam logic [3:0] CODE_MSI = 4'd3;
  localparam logic [3:0] CODE_MTI = 4'd7;
  localparam logic [3:0] CODE_MEI = 4'd11;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } irq_state_e;

  // Interrupt cause word: interrupt flag in bit 31, code in the low nibble
  function automatic logic [31:0] mk_cause(input logic [3:0] code);
    return {1'b1, 27'b0, code};
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchroniser for a single asynchronous level input.
// Latency: STAGES clk from input change to q.
// Backpressure: none; samples every cycle.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // Shift the asynchronous level through the flop chain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/irq_ctrl.sv
// Machine-mode interrupt controller: owns mstatus.MIE/MPIE, mie, mip, mtvec, mepc, mcause; raises traps, handles mret.
// Latency: trap_req 1 clk after a qualifying MTIP/MSIP, SYNC_STAGES+1 clk after MEIP.
// Backpressure: trap_req/trap_cause hold until trap_ack, or withdraw if the latched source gets masked.
module irq_ctrl
  import irq_pkg::*;
#(
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] MTVEC_RST   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        int_timer,
  input  logic        int_soft,
  input  logic        int_ext,
  input  logic        csr_sel,
  input  logic [11:0] csr_addr,
  input  logic        csr_we,
  input  logic [31:0] csr_wdata,
  output logic [31:0] csr_rdata,
  input  logic [31:0] trap_pc,
  input  logic        trap_ack,
  input  logic        mret,
  output logic        trap_req,
  output logic [31:0] trap_cause,
  output logic [31:0] mtvec_o,
  output logic [31:0] mepc_o
);

  irq_state_e  state;
  logic        st_mie;
  logic        st_mpie;
  logic [31:0] mie_r;
  logic [31:2] mtvec_r;
  logic [31:2] mepc_r;
  logic [31:0] mcause_r;

  logic        meip_s;
  logic        csr_wr;
  logic [31:0] mip;
  logic [31:0] pending;
  logic [31:0] mstatus_rd;
  logic [3:0]  win_code;
  logic        take_trap;
  logic        cause_en;
  logic        withdraw;

  sync_ff #(
    .STAGES (SYNC_STAGES)
  ) u_meip_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (int_ext),
    .q     (meip_s)
  );

  assign csr_wr   = csr_sel & csr_we;
  assign trap_req = (state == REQ);
  assign mtvec_o  = {mtvec_r, 2'b00};
  assign mepc_o   = {mepc_r, 2'b00};

  // Pending/priority evaluation, withdraw condition and CSR read mux
  always_comb begin
    mip          = '0;
    mip[MEI]     = meip_s;
    mip[MTI]     = int_timer;
    mip[MSI]     = int_soft;
    pending      = mip & mie_r;

    mstatus_rd           = '0;
    mstatus_rd[12:11]    = 2'b11;
    mstatus_rd[MIE_BIT]  = st_mie;
    mstatus_rd[MPIE_BIT] = st_mpie;

    // Later assignments override earlier ones: MEI > MSI > MTI
    win_code = CODE_MTI;
    if (pending[MSI]) win_code = CODE_MSI;
    if (pending[MEI]) win_code = CODE_MEI;

    // mret owns its cycle; no new trap is started while MIE is being restored
    take_trap = (state == IDLE) && st_mie && (|pending) && !mret;

    // Enable bit of the cause already latched, not of the current winner
    cause_en = 1'b0;
    case (trap_cause[3:0])
      CODE_MEI: cause_en = mie_r[MEI];
      CODE_MSI: cause_en = mie_r[MSI];
      CODE_MTI: cause_en = mie_r[MTI];
      default:  cause_en = 1'b0;
    endcase
    withdraw = !st_mie || !cause_en;

    csr_rdata = '0;
    if (csr_sel) begin
      case (csr_addr)
        CSR_MSTATUS: csr_rdata = mstatus_rd;
        CSR_MIE:     csr_rdata = mie_r;
        CSR_MTVEC:   csr_rdata = {mtvec_r, 2'b00};
        CSR_MEPC:    csr_rdata = {mepc_r, 2'b00};
        CSR_MCAUSE:  csr_rdata = mcause_r;
        CSR_MIP:     csr_rdata = mip;
        default:     csr_rdata = '0;
      endcase
    end
  end

  // CSR writes, then FSM/mret/ack updates; later assignments win on conflicts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      st_mie     <= 1'b0;
      st_mpie    <= 1'b0;
      mie_r      <= '0;
      mtvec_r    <= MTVEC_RST[31:2];
      mepc_r     <= '0;
      mcause_r   <= '0;
      trap_cause <= '0;
    end else begin
      if (csr_wr) begin
        case (csr_addr)
          CSR_MSTATUS: begin
            st_mie  <= csr_wdata[MIE_BIT];
            st_mpie <= csr_wdata[MPIE_BIT];
          end
          CSR_MIE:    mie_r    <= csr_wdata & MIE_MASK;
          CSR_MTVEC:  mtvec_r  <= csr_wdata[31:2];
          CSR_MEPC:   mepc_r   <= csr_wdata[31:2];
          CSR_MCAUSE: mcause_r <= csr_wdata;
          default: ;
        endcase
      end

      case (state)
        IDLE: begin
          if (mret) begin
            st_mie  <= st_mpie;
            st_mpie <= 1'b1;
          end else if (take_trap) begin
            state      <= REQ;
            trap_cause <= mk_cause(win_code);
          end
        end
        REQ: begin
          // An ack means the core already committed to the trap, so it is
          // honoured even if the source was masked in the same cycle.
          if (trap_ack) begin
            state    <= IDLE;
            mepc_r   <= trap_pc[31:2];
            mcause_r <= trap_cause;
            st_mpie  <= st_mie;
            st_mie   <= 1'b0;
          end else if (withdraw) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
module tb_irq_ctrl;
  import irq_pkg::*;

  localparam logic [31:0] MTVEC_RST = 32'h0000_2003;
  localparam logic [31:0] MTVEC_EXP = 32'h0000_2000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        int_timer, int_soft, int_ext;
  logic        csr_sel, csr_we;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata, csr_rdata;
  logic [31:0] trap_pc;
  logic        trap_ack, mret;
  logic        trap_req;
  logic [31:0] trap_cause, mtvec_o, mepc_o;

  always #5 clk = ~clk;

  irq_ctrl #(
    .SYNC_STAGES (2),
    .MTVEC_RST   (MTVEC_RST)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .int_timer  (int_timer),
    .int_soft   (int_soft),
    .int_ext    (int_ext),
    .csr_sel    (csr_sel),
    .csr_addr   (csr_addr),
    .csr_we     (csr_we),
    .csr_wdata  (csr_wdata),
    .csr_rdata  (csr_rdata),
    .trap_pc    (trap_pc),
    .trap_ack   (trap_ack),
    .mret       (mret),
    .trap_req   (trap_req),
    .trap_cause (trap_cause),
    .mtvec_o    (mtvec_o),
    .mepc_o     (mepc_o)
  );

  // Scoreboard entry: which output to sample, in which cycle, and its value
  typedef struct {
    int          due;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t  expq[$];
  string nameq[$];
  int    cyc   = 0;
  int    total = 0;
  int    bad   = 0;

  localparam int S_RDATA = 0;
  localparam int S_REQ   = 1;
  localparam int S_CAUSE = 2;
  localparam int S_MEPC  = 3;
  localparam int S_MTVEC = 4;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] probe(input int sel);
    case (sel)
      S_RDATA: return csr_rdata;
      S_REQ:   return {31'b0, trap_req};
      S_CAUSE: return trap_cause;
      S_MEPC:  return mepc_o;
      default: return mtvec_o;
    endcase
  endfunction

  // Monitor: pops every expectation due this cycle and compares mid-cycle
  always @(negedge clk) begin : monitor
    exp_t        e;
    string       n;
    logic [31:0] act;
    while (expq.size() != 0 && expq[0].due <= cyc) begin
      e   = expq.pop_front();
      n   = nameq.pop_front();
      act = probe(e.sel);
      total++;
      if (act !== e.exp) begin
        bad++;
        $display("FAIL %s: got 0x%08h want 0x%08h", n, act, e.exp);
      end
    end
  end

  task automatic chk(input int sel, input logic [31:0] v, input string n);
    exp_t e;
    e.due = cyc;
    e.sel = sel;
    e.exp = v;
    expq.push_back(e);
    nameq.push_back(n);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    csr_sel   = 1'b0;
    csr_we    = 1'b0;
    csr_addr  = '0;
    csr_wdata = '0;
    trap_ack  = 1'b0;
    mret      = 1'b0;
  endtask

  task automatic set_wr(input logic [11:0] a, input logic [31:0] d);
    csr_sel   = 1'b1;
    csr_we    = 1'b1;
    csr_addr  = a;
    csr_wdata = d;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    step();
    set_wr(a, d);
  endtask

  task automatic rd(input logic [11:0] a, input logic [31:0] e, input string n);
    step();
    csr_sel  = 1'b1;
    csr_addr = a;
    chk(S_RDATA, e, n);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation still running at 200000, want finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    int_timer = 1'b0; int_soft = 1'b0; int_ext = 1'b0;
    csr_sel = 1'b0; csr_we = 1'b0; csr_addr = '0; csr_wdata = '0;
    trap_pc = '0; trap_ack = 1'b0; mret = 1'b0;

    // T1 reset values
    repeat (3) step();
    chk(S_REQ, 32'd0, "rst_trap_req");
    rst_n = 1'b1;
    rd(CSR_MSTATUS, 32'h0000_1800, "rst_mstatus");
    rd(CSR_MIE,     32'h0,         "rst_mie");
    rd(CSR_MTVEC,   MTVEC_EXP,     "rst_mtvec");
    chk(S_MTVEC, MTVEC_EXP, "rst_mtvec_o");
    rd(CSR_MEPC,    32'h0,         "rst_mepc");
    rd(CSR_MCAUSE,  32'h0,         "rst_mcause");
    rd(CSR_MIP,     32'h0,         "rst_mip");

    // T2 timer trap and ack
    wr(CSR_MIE, 32'h80);
    wr(CSR_MSTATUS, 32'h8);
    step(); int_timer = 1'b1; chk(S_REQ, 32'd0, "t2_no_req_yet");
    step();
    chk(S_REQ, 32'd1, "t2_req");
    chk(S_CAUSE, 32'h8000_0007, "t2_cause");
    trap_pc = 32'h100; trap_ack = 1'b1;
    step();
    chk(S_REQ, 32'd0, "t2_req_drop");
    chk(S_MEPC, 32'h100, "t2_mepc_o");
    rd(CSR_MEPC,    32'h100,       "t2_mepc");
    rd(CSR_MSTATUS, 32'h0000_1880, "t2_mstatus");
    rd(CSR_MCAUSE,  32'h8000_0007, "t2_mcause");

    // T5 mret restores MIE; timer still high re-requests one cycle later
    step(); mret = 1'b1; chk(S_REQ, 32'd0, "t5_mret_cycle");
    rd(CSR_MSTATUS, 32'h0000_1888, "t5_mstatus");
    chk(S_REQ, 32'd0, "t5_no_req_after_mret_edge");
    wr(CSR_MIE, 32'h888); int_soft = 1'b1;
    chk(S_REQ, 32'd1, "t5_rereq");
    chk(S_CAUSE, 32'h8000_0007, "t5_cause");
    step(); chk(S_REQ, 32'd1, "t5_req_held");

    // Cause stays frozen while a higher-priority source is now pending
    wr(CSR_MSTATUS, 32'h0);
    chk(S_REQ, 32'd1, "frozen_req");
    chk(S_CAUSE, 32'h8000_0007, "frozen_cause");

    // T4 withdraw after MIE cleared; trap CSRs untouched
    step();
    step(); chk(S_REQ, 32'd0, "t4_withdraw");
    rd(CSR_MEPC,    32'h100,       "t4_mepc");
    rd(CSR_MCAUSE,  32'h8000_0007, "t4_mcause");
    rd(CSR_MSTATUS, 32'h0000_1800, "t4_mstatus");

    // T3 priority: MEI beats MSI and MTI when enabled together
    step(); int_ext = 1'b1;
    repeat (3) step();
    wr(CSR_MSTATUS, 32'h8); chk(S_REQ, 32'd0, "t3_pre0");
    step(); chk(S_REQ, 32'd0, "t3_pre1");
    step();
    chk(S_REQ, 32'd1, "t3_req");
    chk(S_CAUSE, 32'h8000_000B, "t3_cause_mei");
    trap_pc = 32'h207; trap_ack = 1'b1;
    step(); chk(S_REQ, 32'd0, "t3_ack_drop");
    rd(CSR_MEPC,    32'h204,       "t3_mepc_aligned");
    rd(CSR_MCAUSE,  32'h8000_000B, "t3_mcause");
    rd(CSR_MSTATUS, 32'h0000_1880, "t3_mstatus");

    // Soft alone -> code 3; ack beats a same-cycle mepc write
    step(); int_ext = 1'b0; int_timer = 1'b0;
    repeat (3) step();
    wr(CSR_MSTATUS, 32'h8);
    step();
    step();
    chk(S_REQ, 32'd1, "soft_req");
    chk(S_CAUSE, 32'h8000_0003, "soft_cause");
    trap_pc = 32'h300; trap_ack = 1'b1;
    set_wr(CSR_MEPC, 32'hDEAD_BEE0);
    step(); chk(S_REQ, 32'd0, "soft_ack_drop");
    rd(CSR_MEPC,   32'h300,       "ack_beats_mepc_wr");
    rd(CSR_MCAUSE, 32'h8000_0003, "soft_mcause");
    int_soft = 1'b0;

    // MEIP latency is SYNC_STAGES+1 clk; withdraw via mie bit of latched cause
    wr(CSR_MSTATUS, 32'h88);
    step(); chk(S_REQ, 32'd0, "ext_idle");
    step(); int_ext = 1'b1; chk(S_REQ, 32'd0, "ext_lat0");
    step(); chk(S_REQ, 32'd0, "ext_lat1");
    step(); chk(S_REQ, 32'd0, "ext_lat2");
    step();
    chk(S_REQ, 32'd1, "ext_lat3");
    chk(S_CAUSE, 32'h8000_000B, "ext_cause");
    set_wr(CSR_MIE, 32'h88);
    step();
    step(); chk(S_REQ, 32'd0, "mie_withdraw");
    rd(CSR_MSTATUS, 32'h0000_1888, "withdraw_mstatus");
    rd(CSR_MCAUSE,  32'h8000_0003, "withdraw_mcause");
    rd(CSR_MEPC,    32'h300,       "withdraw_mepc");

    // T6 read-only mip, mtvec alignment, csr_sel gating, unlisted address
    wr(CSR_MSTATUS, 32'h0);
    int_ext = 1'b0; int_timer = 1'b1;
    repeat (3) step();
    wr(CSR_MIP, 32'hFFFF_FFFF);
    rd(CSR_MIP, 32'h80, "mip_timer_only");
    step(); int_soft = 1'b1;
    rd(CSR_MIP, 32'h88, "mip_timer_soft");
    step(); int_ext = 1'b1;
    repeat (3) step();
    rd(CSR_MIP, 32'h888, "mip_all");
    wr(CSR_MTVEC, 32'h1003);
    rd(CSR_MTVEC, 32'h1000, "mtvec_aligned");
    chk(S_MTVEC, 32'h1000, "mtvec_o");
    step(); csr_addr = CSR_MSTATUS; chk(S_RDATA, 32'h0, "sel0_rdata");
    wr(12'h340, 32'h1234_5678);
    rd(12'h340, 32'h0, "unlisted_addr");

    // Reset while requesting drops trap_req asynchronously
    int_soft = 1'b0; int_ext = 1'b0;
    wr(CSR_MSTATUS, 32'h8);
    step();
    step(); chk(S_REQ, 32'd1, "pre_reset_req");
    step(); rst_n = 1'b0; chk(S_REQ, 32'd0, "async_reset_req");
    step(); rst_n = 1'b1;
    rd(CSR_MSTATUS, 32'h0000_1800, "post_reset_mstatus");
    rd(CSR_MTVEC,   MTVEC_EXP,     "post_reset_mtvec");
    rd(CSR_MEPC,    32'h0,         "post_reset_mepc");
    int_timer = 1'b0;

    repeat (3) step();
    if (expq.size() != 0) begin
      total++;
      bad++;
      $display("FAIL queue_drain: left=%0d want 0", expq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
